// File: rtl/rev_pe_err_logger.sv
// Error-event logger for the reversible multiply-add PE: synchronises the PE check
// flags, counts flagged cycles per run, records the first error and serves a register read port.
module rev_pe_err_logger #(
  parameter int unsigned DATA_NUM    = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_start,
  input  logic        clear,
  input  logic        pe_vld,
  input  logic        err1_in,
  input  logic        err2_in,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        irq_done
);

  localparam int unsigned IdxW  = $clog2(DATA_NUM) + 1;
  localparam int unsigned DrainW = $clog2(SYNC_STAGES + 2);
  localparam logic [IdxW-1:0]      LastIdx   = IdxW'(DATA_NUM - 1);
  localparam logic [DrainW-1:0]    DrainLoad = DrainW'(SYNC_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] CntMax    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync2_q;
  logic                   s_err1, s_err2;
  logic [CNT_WIDTH-1:0]   err1_cnt_q, err1_cnt_d, err2_cnt_q, err2_cnt_d;
  logic [IdxW-1:0]        sample_idx_q, sample_idx_d, first_err_idx_q, first_err_idx_d;
  logic [1:0]             first_err_kind_q, first_err_kind_d;
  logic                   first_err_valid_q, first_err_valid_d;
  logic [DrainW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [15:0]            rd_data_q, rd_data_d;
  logic                   rd_valid_q;
  logic                   counting, any_err;

  assign s_err1   = sync1_q[SYNC_STAGES-1];
  assign s_err2   = sync2_q[SYNC_STAGES-1];
  assign counting = (state_q == StArmed) || (state_q == StDrain);
  assign any_err  = (err1_cnt_q != '0) || (err2_cnt_q != '0);

  always_comb begin
    state_d           = state_q;
    err1_cnt_d        = err1_cnt_q;
    err2_cnt_d        = err2_cnt_q;
    sample_idx_d      = sample_idx_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_kind_d  = first_err_kind_q;
    first_err_valid_d = first_err_valid_q;
    drain_cnt_d       = drain_cnt_q;

    if (run_start || clear) begin
      err1_cnt_d        = '0;
      err2_cnt_d        = '0;
      sample_idx_d      = '0;
      first_err_idx_d   = '0;
      first_err_kind_d  = '0;
      first_err_valid_d = 1'b0;
      drain_cnt_d       = '0;
      state_d           = run_start ? StArmed : StIdle;
    end else begin
      if (counting) begin
        if (s_err1 && (err1_cnt_q != CntMax)) err1_cnt_d = err1_cnt_q + 1'b1;
        if (s_err2 && (err2_cnt_q != CntMax)) err2_cnt_d = err2_cnt_q + 1'b1;
        // Index is the pre-increment value of the cycle the flag is seen.
        if ((s_err1 || s_err2) && !first_err_valid_q) begin
          first_err_idx_d   = sample_idx_q;
          first_err_kind_d  = {s_err2, s_err1};
          first_err_valid_d = 1'b1;
        end
      end

      case (state_q)
        StArmed: begin
          if (pe_vld) begin
            sample_idx_d = sample_idx_q + 1'b1;
            if (sample_idx_q == LastIdx) begin
              state_d     = StDrain;
              drain_cnt_d = DrainLoad;
            end
          end
        end
        // Drain lets flags raised alongside the last result clear the synchroniser.
        StDrain: begin
          if (drain_cnt_q == '0) state_d = StDone;
          else drain_cnt_d = drain_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (rd_addr)
        3'd0:    rd_data_d = {11'b0, any_err, first_err_valid_q, 1'b0, state_q};
        3'd1:    rd_data_d = 16'(err1_cnt_q);
        3'd2:    rd_data_d = 16'(err2_cnt_q);
        3'd3:    rd_data_d = {first_err_kind_q, 6'b0, 8'(first_err_idx_q)};
        3'd4:    rd_data_d = 16'(sample_idx_q);
        default: rd_data_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      sync1_q           <= '0;
      sync2_q           <= '0;
      err1_cnt_q        <= '0;
      err2_cnt_q        <= '0;
      sample_idx_q      <= '0;
      first_err_idx_q   <= '0;
      first_err_kind_q  <= '0;
      first_err_valid_q <= 1'b0;
      drain_cnt_q       <= '0;
      rd_data_q         <= '0;
      rd_valid_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      sync1_q           <= {sync1_q[SYNC_STAGES-2:0], err1_in};
      sync2_q           <= {sync2_q[SYNC_STAGES-2:0], err2_in};
      err1_cnt_q        <= err1_cnt_d;
      err2_cnt_q        <= err2_cnt_d;
      sample_idx_q      <= sample_idx_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_kind_q  <= first_err_kind_d;
      first_err_valid_q <= first_err_valid_d;
      drain_cnt_q       <= drain_cnt_d;
      rd_data_q         <= rd_data_d;
      rd_valid_q        <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq_done = (state_q == StDone);

endmodule
